// File: rtl/quad_encoder_emulator_if.sv
// Command handshake and pin bundle between an encoder-emulation requester and the emulator.
// The requester drives the command fields and abort; the emulator returns the pins and status.
interface quad_encoder_emulator_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_sel;
    logic       cmd_dir;
    logic [7:0] cmd_steps;
    logic       abort;
    logic [3:0] encoder;
    logic       busy;
    logic       done;
    logic [7:0] steps_done;

    modport master (
        output cmd_valid, cmd_sel, cmd_dir, cmd_steps, abort,
        input  cmd_ready, encoder, busy, done, steps_done
    );

    modport slave (
        input  cmd_valid, cmd_sel, cmd_dir, cmd_steps, abort,
        output cmd_ready, encoder, busy, done, steps_done
    );
endinterface

// File: rtl/quad_encoder_emulator.sv
// Emits N quadrature detents on one of two encoder pin pairs per accepted command.
// Each phase is held PHASE_CYC cycles so the downstream debounce always sees a clean level.
module quad_encoder_emulator #(
    parameter int PHASE_CYC = 40
) (
    input  logic                    clk_10k,
    input  logic                    rst,
    quad_encoder_emulator_if.slave  bus
);
    localparam logic [9:0] LP_RELOAD = 10'(PHASE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PH1,
        S_PH2,
        S_PH3,
        S_PH4,
        S_ZDONE
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [9:0] r_timer;
    logic       r_go;
    logic       r_abort;
    logic       r_sel;
    logic       r_dir;
    logic [7:0] r_steps;
    logic [7:0] r_steps_done;
    logic [3:0] r_enc;
    logic       r_busy;
    logic       r_done;

    logic       w_ready;
    logic       w_fire;
    logic       w_ph_end;
    logic       w_last;
    logic [3:0] w_enc_nxt;
    logic       w_done_nxt;

    function automatic logic [1:0] f_pins(input state_t s, input logic dir);
        logic [1:0] v;
        v = 2'b00;
        case (s)
            S_PH1:   v = dir ? 2'b10 : 2'b01;
            S_PH2:   v = 2'b11;
            S_PH3:   v = dir ? 2'b01 : 2'b10;
            default: v = 2'b00;
        endcase
        return v;
    endfunction

    // r_go delays the start by one edge so pins first move on the edge after acceptance
    assign w_ready  = (r_state == S_IDLE) && !r_go && !rst;
    assign w_fire   = bus.cmd_valid && w_ready;
    assign w_ph_end = (r_timer == 10'd0);
    assign w_last   = (({1'b0, r_steps_done} + 9'd1) == {1'b0, r_steps}) || r_abort || bus.abort;

    always_comb begin
        w_state_nxt = r_state;
        w_enc_nxt   = 4'b0000;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE:  if (r_go) w_state_nxt = (r_steps == 8'd0) ? S_ZDONE : S_PH1;
            S_PH1:   if (w_ph_end) w_state_nxt = S_PH2;
            S_PH2:   if (w_ph_end) w_state_nxt = S_PH3;
            S_PH3:   if (w_ph_end) w_state_nxt = S_PH4;
            S_PH4:   if (w_ph_end) w_state_nxt = w_last ? S_IDLE : S_PH1;
            S_ZDONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (r_sel) w_enc_nxt = {2'b00, f_pins(w_state_nxt, r_dir)};
        else       w_enc_nxt = {f_pins(w_state_nxt, r_dir), 2'b00};
        w_done_nxt = ((r_state == S_PH4) && (w_state_nxt == S_IDLE)) || (w_state_nxt == S_ZDONE);
    end

    always_ff @(posedge clk_10k) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_timer      <= 10'd0;
            r_go         <= 1'b0;
            r_abort      <= 1'b0;
            r_steps_done <= 8'd0;
            r_enc        <= 4'b0000;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_enc   <= w_enc_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != S_IDLE) || w_fire;
            r_go    <= w_fire;
            if (w_state_nxt != r_state) r_timer <= LP_RELOAD;
            else if (!w_ph_end)         r_timer <= r_timer - 10'd1;
            if (w_fire)                                  r_abort <= 1'b0;
            else if (r_state != S_IDLE && bus.abort)     r_abort <= 1'b1;
            if (w_fire)                                  r_steps_done <= 8'd0;
            else if (r_state == S_PH4 && w_ph_end)       r_steps_done <= r_steps_done + 8'd1;
        end
    end

    // Command fields are held from acceptance onward and ignore later input changes
    always_ff @(posedge clk_10k) begin
        if (w_fire) begin
            r_sel   <= bus.cmd_sel;
            r_dir   <= bus.cmd_dir;
            r_steps <= bus.cmd_steps;
        end
    end

    assign bus.cmd_ready  = w_ready;
    assign bus.encoder    = r_enc;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.steps_done = r_steps_done;
endmodule
